// File: rtl/uart_rx_os16_pkg.sv
// uart_rx_os16_pkg: shared UART receive state encoding and default widths
package uart_rx_os16_pkg;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_CNT_W = $clog2(DEF_OVERSAMPLE);
  localparam int DEF_IDX_W = $clog2(DEF_DATA_BITS + 1);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;
endpackage

// File: rtl/uart_rx_os16_if.sv
// uart_rx_os16_if: received-byte handshake between receiver and consumer
interface uart_rx_os16_if
  import uart_rx_os16_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);
  logic                 rdy_clr;
  logic [DATA_BITS-1:0] data;
  logic                 rdy;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
  modport master(input rdy_clr, output data, rdy, frame_err, overrun, busy);
  modport slave(output rdy_clr, input data, rdy, frame_err, overrun, busy);
endinterface

// File: rtl/uart_rx_os16_sync_bit.sv
// sync_bit: metastability flop chain that resets to the idle-high level
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_sync;
  // shift the asynchronous input through the chain every clock
  always_ff @(posedge clk)
    r_sync <= rst ? '1 : {r_sync[STAGES-2:0], d};
  assign q = r_sync[STAGES-1];
endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampling 8N1 UART receiver with ready/clear handshake
module uart_rx_os16
  import uart_rx_os16_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_50m,
  input  logic           rst,
  input  logic           clken,
  input  logic           rx,
  uart_rx_os16_if.master bus
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] TOP  = IDX_W'(DATA_BITS - 1);
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_sh;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rdy;
  logic                 r_fe;
  logic                 r_ov;
  logic                 w_rx_s;
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_50m),
    .rst(rst),
    .d  (rx),
    .q  (w_rx_s)
  );
  // frame recovery FSM; the clear path runs every cycle, framing only on clken
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_fe    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      if (bus.rdy_clr) begin
        r_rdy <= 1'b0;
        r_fe  <= 1'b0;
        r_ov  <= 1'b0;
      end
      if (clken)
        case (r_state)
          IDLE:
            if (!w_rx_s) begin
              r_state <= START;
              r_cnt   <= '0;
            end
          START:
            if (r_cnt == HALF) begin
              r_cnt   <= '0;
              r_idx   <= '0;
              r_state <= w_rx_s ? IDLE : DATA;
            end else r_cnt <= r_cnt + 1'b1;
          DATA:
            if (r_cnt == LAST) begin
              r_cnt <= '0;
              r_sh  <= {w_rx_s, r_sh[DATA_BITS-1:1]};
              r_idx <= r_idx + 1'b1;
              if (r_idx == TOP) r_state <= STOP;
            end else r_cnt <= r_cnt + 1'b1;
          STOP:
            if (r_cnt == LAST) begin
              r_cnt <= '0;
              if (w_rx_s) begin
                r_data  <= r_sh;
                r_rdy   <= 1'b1;
                if (r_rdy && !bus.rdy_clr) r_ov <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_fe    <= 1'b1;
                r_state <= WAIT_IDLE;
              end
            end else r_cnt <= r_cnt + 1'b1;
          WAIT_IDLE:
            if (w_rx_s) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
    end
  end
  assign bus.data      = r_data;
  assign bus.rdy       = r_rdy;
  assign bus.frame_err = r_fe;
  assign bus.overrun   = r_ov;
  assign bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: directed frame scenarios against the 16x UART receiver
module tb_uart_rx_os16;
  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       clken = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] ph = 2'd0;
  int         vectors = 0;
  int         errors = 0;
  int         rises = 0;
  logic       prev_rdy = 1'b0;
  int         lat = 0;

  uart_rx_os16_if bus ();

  uart_rx_os16 dut (
    .clk_50m(clk_50m),
    .rst    (rst),
    .clken  (clken),
    .rx     (rx),
    .bus    (bus)
  );

  initial forever #5 clk_50m = ~clk_50m;

  initial forever begin
    @(negedge clk_50m);
    ph = ph + 2'd1;
    clken = (ph == 2'd0);
  end

  initial forever begin
    @(negedge clk_50m);
    if (bus.rdy && !prev_rdy) rises++;
    prev_rdy = bus.rdy;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic align();
    @(negedge clk_50m);
    #1;
    while (!clken) begin
      @(negedge clk_50m);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cyc(64);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(64);
    end
    rx = stop;
    cyc(64);
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m);
    bus.rdy_clr = 1'b1;
    @(negedge clk_50m);
    bus.rdy_clr = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    bus.rdy_clr = 1'b0;
    rst = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(2);
    vectors++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", bus.data); end
    vectors++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", bus.rdy); end
    vectors++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got=%b exp=0", bus.frame_err); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", bus.overrun); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    align();
    rx = 1'b0;
    repeat (26) begin
      @(negedge clk_50m);
      if (bus.busy) seen = 1'b1;
    end
    rx = 1'b1;
    repeat (60) begin
      @(negedge clk_50m);
      if (bus.busy) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse got=%b exp=1", seen); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear got=%b exp=0", bus.busy); end
    vectors++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy got=%b exp=0", bus.rdy); end
    vectors++; if (bus.data !== 8'h00) begin errors++; $display("FAIL glitch_data got=%h exp=00", bus.data); end
  endtask

  task automatic test_basic();
    int r0;
    r0 = rises;
    align();
    send(8'hA5, 1'b1);
    cyc(8);
    vectors++; if (rises - r0 !== 1) begin errors++; $display("FAIL basic_rdy_rises got=%0d exp=1", rises - r0); end
    vectors++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", bus.data); end
    vectors++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy got=%b exp=1", bus.rdy); end
    vectors++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL basic_fe got=%b exp=0", bus.frame_err); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL basic_ov got=%b exp=0", bus.overrun); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", bus.busy); end
    pulse_clr();
    vectors++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL basic_clr_rdy got=%b exp=0", bus.rdy); end
    vectors++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL basic_clr_data got=%h exp=a5", bus.data); end
  endtask

  task automatic test_framing();
    align();
    send(8'h3C, 1'b0);
    cyc(160);
    vectors++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL frame_fe got=%b exp=1", bus.frame_err); end
    vectors++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL frame_rdy got=%b exp=0", bus.rdy); end
    vectors++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL frame_data got=%h exp=a5", bus.data); end
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL frame_wait_idle got=%b exp=1", bus.busy); end
    rx = 1'b1;
    cyc(16);
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL frame_release got=%b exp=0", bus.busy); end
    align();
    send(8'h81, 1'b1);
    cyc(8);
    vectors++; if (bus.data !== 8'h81) begin errors++; $display("FAIL frame_next_data got=%h exp=81", bus.data); end
    vectors++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL frame_next_rdy got=%b exp=1", bus.rdy); end
    vectors++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL frame_sticky got=%b exp=1", bus.frame_err); end
    pulse_clr();
    vectors++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL frame_clr_fe got=%b exp=0", bus.frame_err); end
    vectors++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL frame_clr_rdy got=%b exp=0", bus.rdy); end
  endtask

  task automatic test_back_to_back();
    align();
    send(8'h11, 1'b1);
    vectors++; if (bus.data !== 8'h11) begin errors++; $display("FAIL b2b_first_data got=%h exp=11", bus.data); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_first_ov got=%b exp=0", bus.overrun); end
    send(8'h22, 1'b1);
    cyc(8);
    vectors++; if (bus.data !== 8'h22) begin errors++; $display("FAIL b2b_data got=%h exp=22", bus.data); end
    vectors++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy got=%b exp=1", bus.rdy); end
    vectors++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL b2b_ov got=%b exp=1", bus.overrun); end
    pulse_clr();
    vectors++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL b2b_clr_rdy got=%b exp=0", bus.rdy); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_clr_ov got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_clr_collision();
    int n;
    n = 0;
    align();
    fork
      send(8'h5A, 1'b1);
      begin
        while (!bus.rdy && n < 2000) begin
          @(negedge clk_50m);
          n++;
        end
      end
    join
    lat = n;
    vectors++; if (bus.data !== 8'h5A) begin errors++; $display("FAIL coll_prior_data got=%h exp=5a", bus.data); end
    vectors++; if (lat < 604 || lat > 620) begin errors++; $display("FAIL coll_latency got=%0d exp=604..620", lat); end
    if (lat < 2 || lat > 700) lat = 612;
    align();
    fork
      send(8'h7E, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk_50m);
        bus.rdy_clr = 1'b1;
        @(negedge clk_50m);
        bus.rdy_clr = 1'b0;
      end
    join
    cyc(8);
    vectors++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL coll_rdy got=%b exp=1", bus.rdy); end
    vectors++; if (bus.data !== 8'h7E) begin errors++; $display("FAIL coll_data got=%h exp=7e", bus.data); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL coll_ov got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_reset_mid_frame();
    align();
    rx = 1'b0;
    cyc(64);
    rx = 1'b1;
    cyc(64 * 3 + 20);
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", bus.busy); end
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    vectors++; if (bus.data !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h exp=00", bus.data); end
    vectors++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy got=%b exp=0", bus.rdy); end
    vectors++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_fe got=%b exp=0", bus.frame_err); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL midrst_ov got=%b exp=0", bus.overrun); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    cyc(64);
    align();
    send(8'h55, 1'b1);
    cyc(8);
    vectors++; if (bus.data !== 8'h55) begin errors++; $display("FAIL midrst_next_data got=%h exp=55", bus.data); end
    vectors++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL midrst_next_rdy got=%b exp=1", bus.rdy); end
    vectors++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_next_fe got=%b exp=0", bus.frame_err); end
    vectors++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL midrst_next_ov got=%b exp=0", bus.overrun); end
  endtask

  initial begin
    bus.rdy_clr = 1'b0;
    test_reset();
    test_glitch();
    test_basic();
    test_framing();
    test_back_to_back();
    test_clr_collision();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
